// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic [15:0] TIMEOUT_RDATA = 16'hDEAD;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the core (m0) and the DMA/loader (m1) onto one
// shared bus, with a per-transaction wait timeout and a sticky error flag.
//
//   state | meaning
//   IDLE  | no grant; sample requests and pick the next owner
//   GNT0  | m0 owns the shared bus, waiting for s_ready
//   GNT1  | m1 owns the shared bus, waiting for s_ready
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_valid,
  input  logic [1:0]  m0_wstrb,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ready,
  output logic [15:0] m0_rdata,

  input  logic        m1_valid,
  input  logic [1:0]  m1_wstrb,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ready,
  output logic [15:0] m1_rdata,

  output logic        s_valid,
  output logic [1:0]  s_wstrb,
  output logic [15:0] s_addr,
  output logic [15:0] s_wdata,
  input  logic        s_ready,
  input  logic [15:0] s_rdata,

  input  logic        err_clr,
  output logic        err,
  output logic        err_master
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  arb_state_t  state;
  arb_state_t  state_nxt;
  logic [15:0] wait_cnt;
  logic        last_gnt;
  logic        err_q;
  logic        err_master_q;

  logic        granted;
  logic        cur_idx;
  logic        sel_valid;
  logic        done;
  logic        timeout;

  always_comb begin
    granted   = (state == GNT0) || (state == GNT1);
    cur_idx   = (state == GNT1);
    sel_valid = cur_idx ? m1_valid : m0_valid;
    done      = granted && sel_valid && s_ready;
    timeout   = granted && sel_valid && !s_ready && (wait_cnt == WAIT_LAST);
  end

  // On a tie, grant whichever master was not served last.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (m0_valid && m1_valid) state_nxt = last_gnt ? GNT0 : GNT1;
        else if (m0_valid)        state_nxt = GNT0;
        else if (m1_valid)        state_nxt = GNT1;
        else                      state_nxt = IDLE;
      end
      GNT0, GNT1: begin
        if (!sel_valid || done || timeout) state_nxt = IDLE;
        else                               state_nxt = state;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= 16'd0;
      last_gnt     <= 1'b1;
      err_q        <= 1'b0;
      err_master_q <= 1'b0;
    end else begin
      state <= state_nxt;

      if (!granted)      wait_cnt <= 16'd0;
      else if (!s_ready) wait_cnt <= wait_cnt + 16'd1;

      if (done || timeout) last_gnt <= cur_idx;

      // A timeout in the same cycle as err_clr keeps the flag set.
      if (timeout) begin
        err_q        <= 1'b1;
        err_master_q <= cur_idx;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  // Outputs are held at zero while rst is asserted so an abandoned grant
  // never leaks a request or a ready pulse.
  always_comb begin
    s_valid  = 1'b0;
    s_wstrb  = 2'b00;
    s_addr   = 16'h0;
    s_wdata  = 16'h0;
    m0_ready = 1'b0;
    m0_rdata = 16'h0;
    m1_ready = 1'b0;
    m1_rdata = 16'h0;
    if (!rst) begin
      case (state)
        GNT0: begin
          s_valid  = m0_valid && !timeout;
          s_wstrb  = m0_wstrb;
          s_addr   = m0_addr;
          s_wdata  = m0_wdata;
          m0_ready = done || timeout;
          m0_rdata = timeout ? TIMEOUT_RDATA : s_rdata;
        end
        GNT1: begin
          s_valid  = m1_valid && !timeout;
          s_wstrb  = m1_wstrb;
          s_addr   = m1_addr;
          s_wdata  = m1_wdata;
          m1_ready = done || timeout;
          m1_rdata = timeout ? TIMEOUT_RDATA : s_rdata;
        end
        default: ;
      endcase
    end
  end

  assign err        = err_q && !rst;
  assign err_master = err_master_q && !rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cycle table plus randomized
// traffic compared against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TO = 4;
  localparam logic [15:0] A0 = 16'h1000, A1 = 16'h2000;
  localparam logic [15:0] D0 = 16'hAAAA, D1 = 16'hBBBB;
  localparam logic [1:0]  W0 = 2'b01,    W1 = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m1_valid;
  logic [1:0]  m0_wstrb, m1_wstrb;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ready, m1_ready;
  logic [15:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [1:0]  s_wstrb;
  logic [15:0] s_addr, s_wdata;
  logic        s_ready;
  logic [15:0] s_rdata;
  logic        err_clr, err, err_master;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .err_clr(err_clr), .err(err), .err_master(err_master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic r, v0, v1, sr, clr;
    logic [15:0] srd;
    logic [1:0]  sel;   // 0 none, 1 m0 on bus, 2 m1 on bus
    logic sv, r0, r1;
    logic [15:0] rd;
    logic e, em;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, v0, v1, sr, clr, input logic [15:0] srd,
                              input logic [1:0] sel, input logic sv, r0, r1,
                              input logic [15:0] rd, input logic e, em);
    vec_t v;
    v.r = r; v.v0 = v0; v.v1 = v1; v.sr = sr; v.clr = clr; v.srd = srd;
    v.sel = sel; v.sv = sv; v.r0 = r0; v.r1 = r1; v.rd = rd; v.e = e; v.em = em;
    return v;
  endfunction

  // ---------------- reference model ----------------
  int   own;       // -1 when nobody holds the bus
  int   waited;
  int   last;
  logic merr, merrm;
  logic mv[2];
  logic [15:0] ma[2], md[2];
  logic [1:0]  mw[2];
  logic ex_sv, ex_err, ex_errm;
  logic [1:0]  ex_sw;
  logic [15:0] ex_sa, ex_sd;
  logic ex_rdy[2], ex_rdchk[2];
  logic [15:0] ex_rd[2];

  task automatic model_step(input logic r, input logic srdy, input logic clr,
                            input logic [15:0] srd);
    int n;
    logic set_e;
    ex_sv = 0; ex_sw = 0; ex_sa = 0; ex_sd = 0; ex_err = 0; ex_errm = 0;
    ex_rdy = '{0, 0}; ex_rd = '{16'h0, 16'h0}; ex_rdchk = '{1, 1};
    set_e = 0;
    if (r) begin
      own = -1; last = 1; waited = 0; merr = 0; merrm = 0;
      return;
    end
    ex_err = merr; ex_errm = merrm;
    if (own < 0) begin
      if (mv[0] && mv[1]) own = 1 - last;
      else if (mv[0])     own = 0;
      else if (mv[1])     own = 1;
      waited = 0;
    end else begin
      n = own;
      ex_sv = mv[n]; ex_sw = mw[n]; ex_sa = ma[n]; ex_sd = md[n];
      ex_rdchk[n] = 0;
      if (!mv[n]) begin
        own = -1;
      end else if (srdy) begin
        ex_rdy[n] = 1; ex_rd[n] = srd; ex_rdchk[n] = 1; last = n; own = -1;
      end else if (waited == TO - 1) begin
        ex_rdy[n] = 1; ex_rd[n] = TIMEOUT_RDATA; ex_rdchk[n] = 1; ex_sv = 0;
        set_e = 1; merrm = (n == 1); last = n; own = -1;
      end else begin
        waited++;
      end
    end
    if (set_e)    merr = 1;
    else if (clr) merr = 0;
  endtask

  logic act_rdy[2];
  logic [15:0] act_rd[2];
  logic prev_rdy[2];

  initial begin
    logic [15:0] ea, ed;
    logic [1:0]  ew;
    rst = 1; m0_valid = 0; m1_valid = 0; m0_wstrb = W0; m1_wstrb = W1;
    m0_addr = A0; m1_addr = A1; m0_wdata = D0; m1_wdata = D1;
    s_ready = 0; s_rdata = 0; err_clr = 0;

    // reset / single m0 with ready after 2 cycles
    vecs.push_back(mk(1,1,1,0,0,16'h0,    0,0,0,0,16'h0,   0,0));
    vecs.push_back(mk(0,0,0,0,0,16'h0,    0,0,0,0,16'h0,   0,0));
    vecs.push_back(mk(0,1,0,0,0,16'h0,    0,0,0,0,16'h0,   0,0));
    vecs.push_back(mk(0,1,0,0,0,16'h0,    1,1,0,0,16'h0,   0,0));
    vecs.push_back(mk(0,1,0,0,0,16'h0,    1,1,0,0,16'h0,   0,0));
    vecs.push_back(mk(0,1,0,1,0,16'h1234, 1,1,1,0,16'h1234,0,0));
    vecs.push_back(mk(0,0,0,0,0,16'h0,    0,0,0,0,16'h0,   0,0));
    // ties from reset: m0, m1, m0
    vecs.push_back(mk(1,0,0,0,0,16'h0,    0,0,0,0,16'h0,   0,0));
    vecs.push_back(mk(0,1,1,0,0,16'h0,    0,0,0,0,16'h0,   0,0));
    vecs.push_back(mk(0,1,1,1,0,16'h0A0A, 1,1,1,0,16'h0A0A,0,0));
    vecs.push_back(mk(0,0,1,0,0,16'h0,    0,0,0,0,16'h0,   0,0));
    vecs.push_back(mk(0,0,1,1,0,16'h0B0B, 2,1,0,1,16'h0B0B,0,0));
    vecs.push_back(mk(0,1,1,0,0,16'h0,    0,0,0,0,16'h0,   0,0));
    vecs.push_back(mk(0,1,1,1,0,16'h0C0C, 1,1,1,0,16'h0C0C,0,0));
    vecs.push_back(mk(0,0,0,0,0,16'h0,    0,0,0,0,16'h0,   0,0));
    // m1 timeout on the 4th GNT1 cycle
    vecs.push_back(mk(0,0,1,0,0,16'h0,    0,0,0,0,16'h0,   0,0));
    vecs.push_back(mk(0,0,1,0,0,16'h0,    2,1,0,0,16'h0,   0,0));
    vecs.push_back(mk(0,0,1,0,0,16'h0,    2,1,0,0,16'h0,   0,0));
    vecs.push_back(mk(0,0,1,0,0,16'h0,    2,1,0,0,16'h0,   0,0));
    vecs.push_back(mk(0,0,1,0,0,16'h0,    2,0,0,1,16'hDEAD,0,0));
    vecs.push_back(mk(0,0,0,0,0,16'h0,    0,0,0,0,16'h0,   1,1));
    vecs.push_back(mk(0,0,0,0,1,16'h0,    0,0,0,0,16'h0,   1,1));
    // s_ready on the timeout cycle wins
    vecs.push_back(mk(0,1,0,0,0,16'h0,    0,0,0,0,16'h0,   0,1));
    vecs.push_back(mk(0,1,0,0,0,16'h0,    1,1,0,0,16'h0,   0,1));
    vecs.push_back(mk(0,1,0,0,0,16'h0,    1,1,0,0,16'h0,   0,1));
    vecs.push_back(mk(0,1,0,0,0,16'h0,    1,1,0,0,16'h0,   0,1));
    vecs.push_back(mk(0,1,0,1,0,16'h5555, 1,1,1,0,16'h5555,0,1));
    // err_clr together with a fresh timeout
    vecs.push_back(mk(0,1,0,0,0,16'h0,    0,0,0,0,16'h0,   0,1));
    vecs.push_back(mk(0,1,0,0,0,16'h0,    1,1,0,0,16'h0,   0,1));
    vecs.push_back(mk(0,1,0,0,0,16'h0,    1,1,0,0,16'h0,   0,1));
    vecs.push_back(mk(0,1,0,0,0,16'h0,    1,1,0,0,16'h0,   0,1));
    vecs.push_back(mk(0,1,0,0,1,16'h0,    1,0,1,0,16'hDEAD,0,1));
    vecs.push_back(mk(0,0,0,0,0,16'h0,    0,0,0,0,16'h0,   1,0));
    // m0 drops valid mid-grant, pending m1 goes next
    vecs.push_back(mk(0,1,0,0,0,16'h0,    0,0,0,0,16'h0,   1,0));
    vecs.push_back(mk(0,1,1,0,0,16'h0,    1,1,0,0,16'h0,   1,0));
    vecs.push_back(mk(0,0,1,0,0,16'h0,    1,0,0,0,16'h0,   1,0));
    vecs.push_back(mk(0,0,1,0,0,16'h0,    0,0,0,0,16'h0,   1,0));
    vecs.push_back(mk(0,0,1,0,0,16'h0,    2,1,0,0,16'h0,   1,0));
    // rst during GNT1, next tie to m0, stray s_ready in IDLE
    vecs.push_back(mk(1,1,1,0,0,16'h0,    0,0,0,0,16'h0,   0,0));
    vecs.push_back(mk(0,1,1,0,0,16'h0,    0,0,0,0,16'h0,   0,0));
    vecs.push_back(mk(0,1,1,0,0,16'h0,    1,1,0,0,16'h0,   0,0));
    vecs.push_back(mk(0,0,0,0,0,16'h0,    1,0,0,0,16'h0,   0,0));
    vecs.push_back(mk(0,0,0,1,0,16'h7777, 0,0,0,0,16'h0,   0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst = vecs[i].r; m0_valid = vecs[i].v0; m1_valid = vecs[i].v1;
      s_ready = vecs[i].sr; err_clr = vecs[i].clr; s_rdata = vecs[i].srd;
      @(negedge clk);
      ea = (vecs[i].sel == 2'd1) ? A0 : (vecs[i].sel == 2'd2) ? A1 : 16'h0;
      ed = (vecs[i].sel == 2'd1) ? D0 : (vecs[i].sel == 2'd2) ? D1 : 16'h0;
      ew = (vecs[i].sel == 2'd1) ? W0 : (vecs[i].sel == 2'd2) ? W1 : 2'b00;
      chk($sformatf("tbl%0d s_valid", i), s_valid, vecs[i].sv);
      chk($sformatf("tbl%0d s_addr", i),  s_addr,  ea);
      chk($sformatf("tbl%0d s_wdata", i), s_wdata, ed);
      chk($sformatf("tbl%0d s_wstrb", i), s_wstrb, ew);
      chk($sformatf("tbl%0d m0_ready", i), m0_ready, vecs[i].r0);
      chk($sformatf("tbl%0d m1_ready", i), m1_ready, vecs[i].r1);
      if (vecs[i].r0)         chk($sformatf("tbl%0d m0_rdata", i), m0_rdata, vecs[i].rd);
      if (vecs[i].sel != 2'd1) chk($sformatf("tbl%0d m0_rdata_idle", i), m0_rdata, 16'h0);
      if (vecs[i].r1)         chk($sformatf("tbl%0d m1_rdata", i), m1_rdata, vecs[i].rd);
      if (vecs[i].sel != 2'd2) chk($sformatf("tbl%0d m1_rdata_idle", i), m1_rdata, 16'h0);
      chk($sformatf("tbl%0d err", i), err, vecs[i].e);
      chk($sformatf("tbl%0d err_master", i), err_master, vecs[i].em);
    end

    // ---------------- randomized traffic ----------------
    mv = '{0, 0}; prev_rdy = '{0, 0};
    for (int m = 0; m < 2; m++) begin
      ma[m] = 16'h0; md[m] = 16'h0; mw[m] = 2'b00;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic r_i, sr_i, clr_i;
      logic [15:0] srd_i;
      @(posedge clk); #1;
      r_i = (cyc == 0) || ($urandom_range(0, 199) == 0);
      for (int m = 0; m < 2; m++) begin
        if (!mv[m] || prev_rdy[m]) begin
          mv[m] = ($urandom_range(0, 99) < 45);
          ma[m] = 16'($urandom); md[m] = 16'($urandom); mw[m] = 2'($urandom);
        end else if ($urandom_range(0, 99) < 4) begin
          mv[m] = 0;
        end
      end
      sr_i  = ($urandom_range(0, 99) < 30);
      clr_i = ($urandom_range(0, 99) < 6);
      srd_i = 16'($urandom);
      rst = r_i; s_ready = sr_i; err_clr = clr_i; s_rdata = srd_i;
      m0_valid = mv[0]; m0_addr = ma[0]; m0_wdata = md[0]; m0_wstrb = mw[0];
      m1_valid = mv[1]; m1_addr = ma[1]; m1_wdata = md[1]; m1_wstrb = mw[1];
      @(negedge clk);
      model_step(r_i, sr_i, clr_i, srd_i);
      act_rdy[0] = m0_ready; act_rdy[1] = m1_ready;
      act_rd[0]  = m0_rdata; act_rd[1]  = m1_rdata;
      chk("rnd s_valid", s_valid, ex_sv);
      chk("rnd s_addr",  s_addr,  ex_sa);
      chk("rnd s_wdata", s_wdata, ex_sd);
      chk("rnd s_wstrb", s_wstrb, ex_sw);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("rnd m%0d_ready", m), act_rdy[m], ex_rdy[m]);
        if (ex_rdchk[m]) chk($sformatf("rnd m%0d_rdata", m), act_rd[m], ex_rd[m]);
        prev_rdy[m] = ex_rdy[m];
      end
      chk("rnd err", err, ex_err);
      chk("rnd err_master", err_master, ex_errm);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
